// File: rtl/vec_mul_int_pkg.sv
// Shared types and saturation limits for the sequential elementwise vector multiplier.
// Saturation (used only when VEC_MUL_INT_SAT_EN is defined) is derived from sat_max/sat_min.
package vec_mul_int_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Limits are carried at this width so any legal product width fits in a signed compare.
  localparam int unsigned sat_w = 64;

  function automatic logic signed [sat_w-1:0] sat_max(input int unsigned width,
                                                      input logic is_signed);
    if (is_signed) return (64'sd1 <<< (width - 1)) - 64'sd1;
    return (64'sd1 <<< width) - 64'sd1;
  endfunction

  function automatic logic signed [sat_w-1:0] sat_min(input int unsigned width,
                                                      input logic is_signed);
    if (is_signed) return -(64'sd1 <<< (width - 1));
    return '0;
  endfunction

endpackage

// File: rtl/vec_mul_int_seq_lane.sv
// One combinational multiplier lane: extend, multiply exactly, then wrap or (with
// VEC_MUL_INT_SAT_EN defined) clamp to the prd_width range of the captured signedness.
module vec_mul_lane
  import vec_mul_int_pkg::*;
#(
  parameter int bit_width = 8,
  parameter int prd_width = 2 * bit_width
) (
  input  logic [bit_width-1:0] a,
  input  logic [bit_width-1:0] b,
  input  logic                 is_signed,
  output logic [prd_width-1:0] prd
);

  localparam int full_w = 2 * bit_width + 2;

  logic signed [bit_width:0] a_ext;
  logic signed [bit_width:0] b_ext;
  logic signed [full_w-1:0]  full;

  // One extra bit lets a single signed multiplier serve both operand modes.
  assign a_ext = {is_signed & a[bit_width-1], a};
  assign b_ext = {is_signed & b[bit_width-1], b};
  assign full  = full_w'(a_ext) * full_w'(b_ext);

`ifdef VEC_MUL_INT_SAT_EN
  logic signed [sat_w-1:0] full_x;
  logic signed [sat_w-1:0] hi;
  logic signed [sat_w-1:0] lo;

  // NOTE: every path through this block assigns prd, so no latch is inferred.
  always_comb begin
    full_x = sat_w'(full);
    hi     = sat_max(prd_width, is_signed);
    lo     = sat_min(prd_width, is_signed);
    if (full_x > hi)      prd = hi[prd_width-1:0];
    else if (full_x < lo) prd = lo[prd_width-1:0];
    else                  prd = full_x[prd_width-1:0];
  end
`else
  assign prd = full[prd_width-1:0];
`endif

endmodule

// File: rtl/vec_mul_int_seq.sv
// Sequential elementwise vector multiplier: length/lanes beats per vector pair, valid/ready
// on both sides. Define VEC_MUL_INT_SAT_EN to clamp out-of-range products instead of wrapping.
module vec_mul_int_seq
  import vec_mul_int_pkg::*;
#(
  parameter int bit_width = 8,
  parameter int length    = 32,
  parameter int lanes     = 8,
  parameter int prd_width = 2 * bit_width
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic                        i_signed,
  input  logic [bit_width*length-1:0] i_vec_a,
  input  logic [bit_width*length-1:0] i_vec_b,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [prd_width*length-1:0] o_prd,
  output logic                        o_signed
);

  localparam int beats = length / lanes;
  localparam int k_w   = (beats > 1) ? $clog2(beats) : 1;
  localparam logic [k_w-1:0] k_last = k_w'(beats - 1);

  if (length % lanes != 0) begin : g_bad_cfg
    $error("vec_mul_int_seq: length (%0d) must be a multiple of lanes (%0d)", length, lanes);
  end

  state_t                      state;
  logic [k_w-1:0]              k;
  logic [bit_width*length-1:0] cap_a;
  logic [bit_width*length-1:0] cap_b;
  logic                        cap_signed;
  logic                        accept;

  logic [bit_width-1:0] sel_a    [lanes];
  logic [bit_width-1:0] sel_b    [lanes];
  logic [prd_width-1:0] lane_prd [lanes];

  // In DONE a new vector may only enter when the current result leaves in the same cycle.
  assign o_ready = (state == IDLE) || ((state == DONE) && i_ready);
  assign accept  = i_valid && o_ready;

  for (genvar j = 0; j < lanes; j++) begin : g_lane
    assign sel_a[j] = cap_a[(int'(k) * lanes + j) * bit_width +: bit_width];
    assign sel_b[j] = cap_b[(int'(k) * lanes + j) * bit_width +: bit_width];

    vec_mul_lane #(
      .bit_width(bit_width),
      .prd_width(prd_width)
    ) u_lane (
      .a        (sel_a[j]),
      .b        (sel_b[j]),
      .is_signed(cap_signed),
      .prd      (lane_prd[j])
    );
  end

  // NOTE: operand captures have no reset; they are always rewritten before BUSY reads them.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      cap_a      <= i_vec_a;
      cap_b      <= i_vec_b;
      cap_signed <= i_signed;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      k        <= '0;
      o_valid  <= 1'b0;
      o_signed <= 1'b0;
      o_prd    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= BUSY;
            k     <= '0;
          end
        end
        BUSY: begin
          for (int j = 0; j < lanes; j++) begin
            o_prd[(int'(k) * lanes + j) * prd_width +: prd_width] <= lane_prd[j];
          end
          if (k == k_last) begin
            state    <= DONE;
            o_valid  <= 1'b1;
            o_signed <= cap_signed;
          end else begin
            k <= k + k_w'(1);
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            if (i_valid) begin
              state <= BUSY;
              k     <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mul_int_seq.sv
// Scoreboard bench for vec_mul_int_seq: directed vectors, a decoupled output monitor, and a
// second narrow-product instance whose expectations follow VEC_MUL_INT_SAT_EN.
module tb_vec_mul_int_seq;

  localparam int bw      = 8;
  localparam int len     = 4;
  localparam int ln      = 2;
  localparam int pw      = 16;
  localparam int pw_n    = 12;
  localparam int n_beats = len / ln;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              i_valid  = 1'b0;
  logic              i_signed = 1'b0;
  logic              i_ready  = 1'b0;
  logic              valid_n  = 1'b0;
  logic              ready_n  = 1'b1;
  logic [bw*len-1:0] vec_a    = '0;
  logic [bw*len-1:0] vec_b    = '0;

  logic              o_ready, o_valid, o_signed;
  logic [pw*len-1:0] o_prd;
  logic              o_ready_n, o_valid_n, o_signed_n;
  logic [pw_n*len-1:0] o_prd_n;

  vec_mul_int_seq #(.bit_width(bw), .length(len), .lanes(ln), .prd_width(pw)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_signed(i_signed), .i_vec_a(vec_a), .i_vec_b(vec_b), .o_valid(o_valid),
    .i_ready(i_ready), .o_prd(o_prd), .o_signed(o_signed)
  );

  vec_mul_int_seq #(.bit_width(bw), .length(len), .lanes(ln), .prd_width(pw_n)) dut_n (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_n), .o_ready(o_ready_n),
    .i_signed(i_signed), .i_vec_a(vec_a), .i_vec_b(vec_b), .o_valid(o_valid_n),
    .i_ready(ready_n), .o_prd(o_prd_n), .o_signed(o_signed_n)
  );

  typedef struct {
    logic [pw*len-1:0] prd;
    logic              sgn;
    int                acc;
  } exp_t;

  exp_t                sb[$];
  logic [pw_n*len-1:0] sb_n[$];

  int errors  = 0;
  int checks  = 0;
  int cyc     = 0;
  bit b2b     = 1'b0;
  int last_hs = -1;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Output monitor for the main instance.
  logic              prev_valid  = 1'b0;
  logic              prev_stall  = 1'b0;
  logic [pw*len-1:0] prev_prd    = '0;
  logic              prev_signed = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", o_valid, 1'b1);
        check("hold_prd", o_prd, prev_prd);
        check("hold_signed", o_signed, prev_signed);
      end
      if (o_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got o_prd %h with no vector outstanding", o_prd);
        end else begin
          if (!prev_valid) check("latency", 64'(cyc - sb[0].acc), 64'(n_beats));
          if (i_ready) begin
            exp_t e;
            e = sb.pop_front();
            check("prd", o_prd, e.prd);
            check("signed", o_signed, e.sgn);
            if (b2b && last_hs >= 0) check("spacing", 64'(cyc - last_hs), 64'(n_beats + 1));
            last_hs = cyc;
          end
        end
      end
      prev_stall  = o_valid && !i_ready;
      prev_valid  = o_valid;
      prev_prd    = o_prd;
      prev_signed = o_signed;
    end
  end

  // Output monitor for the narrow instance (always ready).
  always @(negedge clk) begin
    if (rst_n && o_valid_n) begin
      if (sb_n.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_narrow_output: got %h with no vector outstanding", o_prd_n);
      end else begin
        check("narrow_prd", o_prd_n, sb_n.pop_front());
        check("narrow_signed", o_signed_n, 1'b1);
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input logic [bw*len-1:0] a, input logic [bw*len-1:0] b,
                      input logic sgn, input logic [pw*len-1:0] exp_prd);
    int t;
    exp_t e;
    vec_a    = a;
    vec_b    = b;
    i_signed = sgn;
    i_valid  = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (o_ready) break;
      t++;
      if (t > 20) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: o_ready %b after %0d cycles, required 1", o_ready, t);
        break;
      end
    end
    e.prd = exp_prd;
    e.sgn = sgn;
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || sb_n.size() != 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size() + sb_n.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [pw_n*len-1:0] exp_n;
    int t;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 1'b0);
    check("rst_ready", o_ready, 1'b1);
    check("rst_prd", o_prd, '0);
    check("rst_signed", o_signed, 1'b0);
    rst_n   = 1'b1;
    i_ready = 1'b1;
    @(posedge clk);
    #1;

    // Signed: {-128,127,-1,3} x {-128,127,5,-7}
    send(32'h03FF7F80, 32'hF9057F80, 1'b1, 64'hFFEB_FFFB_3F01_4000);
    drain();

    // Unsigned: {255,255,0,1} x {255,1,200,200}
    send(32'h0100FFFF, 32'hC8C801FF, 1'b0, 64'h00C8_0000_00FF_FE01);
    drain();

    // Backpressure: result held for 5 cycles while a new input is offered
    i_ready = 1'b0;
    send(32'h281E140A, 32'h05050505, 1'b0, 64'h00C8_0096_0064_0032);
    t = 0;
    while (!o_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("bp_valid_seen", o_valid, 1'b1);
    @(posedge clk);
    #1;
    vec_a    = 32'h11223344;
    vec_b    = 32'h55667788;
    i_signed = 1'b1;
    i_valid  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_ready", o_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    drain();

    // Back-to-back with i_ready held high
    b2b     = 1'b1;
    last_hs = -1;
    send(32'h9C0AFD02, 32'h9CF60403, 1'b1, 64'h2710_FF9C_FFF4_0006);
    send(32'h07C88010, 32'h09640210, 1'b0, 64'h003F_4E20_0100_0100);
    send(32'h4000FFFF, 32'hFE8001FF, 1'b1, 64'hFF80_0000_FFFF_0001);
    drain();
    b2b = 1'b0;

    // Reset after beat 0: vector is discarded, nothing pushed to the scoreboard
    vec_a    = 32'h03FF7F80;
    vec_b    = 32'hF9057F80;
    i_signed = 1'b1;
    i_valid  = 1'b1;
    @(negedge clk);
    check("rst_test_accept", o_ready, 1'b1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_valid", o_valid, 1'b0);
    check("midrst_prd", o_prd, '0);
    check("midrst_ready", o_ready, 1'b1);
    check("midrst_signed", o_signed, 1'b0);
    repeat (6) @(posedge clk);
    #1;

    // Narrow product: {127,-128,1,-1} x {127,127,-1,-1} at prd_width 12
`ifdef VEC_MUL_INT_SAT_EN
    exp_n = 48'h001_FFF_800_7FF;
`else
    exp_n = 48'h001_FFF_080_F01;
`endif
    vec_a    = 32'hFF01807F;
    vec_b    = 32'hFFFF7F7F;
    i_signed = 1'b1;
    valid_n  = 1'b1;
    @(negedge clk);
    check("narrow_accept", o_ready_n, 1'b1);
    sb_n.push_back(exp_n);
    @(posedge clk);
    #1;
    valid_n = 1'b0;
    drain();

    check("sb_empty", 64'(sb.size() + sb_n.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vec_mul_int_seq.md
# vec_mul_int_seq

Sequential, handshaked successor to the combinational elementwise vector multiplier. Accepts one `length`-element vector pair per transaction and computes elementwise products over `length/lanes` cycles, using `lanes` physical multipliers. Supports per-transaction signed or unsigned operands. Sits between the MX block-operand buffers and the dot-product/accumulate stage, where multiplier count must be traded against throughput.

## Interface

**Parameters**
- `bit_width`, default 8: operand width.
- `length`, default 32: elements per vector.
- `lanes`, default 8: multipliers instantiated. `length % lanes == 0` is required; an elaboration `$error` fires otherwise.
- `prd_width`, default `2*bit_width`: product width, range 2..`2*bit_width+1`.

**Ports**
- `i_clk`, in, 1: the single clock.
- `i_rst_n`, in, 1: reset, synchronous and active-low.
- `i_valid`, in, 1: input vectors valid.
- `o_ready`, out, 1: block can accept input.
- `i_signed`, in, 1: 1 means operands are two's complement; 0 means unsigned.
- `i_vec_a`, in, `bit_width` × `length`: operand A.
- `i_vec_b`, in, `bit_width` × `length`: operand B.
- `o_valid`, out, 1: `o_prd` valid.
- `i_ready`, in, 1: downstream accepts the result.
- `o_prd`, out, `prd_width` × `length`: products, in the same signedness as the inputs.
- `o_signed`, out, 1: the captured `i_signed` of the result.

## Operation

- Let N = `length/lanes`. The FSM has three states: IDLE, BUSY, DONE.
- **IDLE:**
  - `o_ready`=1.
  - On `i_valid`: capture A, B and `i_signed`, clear beat counter `k`, go to BUSY.
- **BUSY:**
  - Each cycle, lanes 0..`lanes`-1 multiply elements `k*lanes+j`.
  - Results are registered into `o_prd[k*lanes+j]`, then `k` increments.
  - After beat N-1, go to DONE.
  - `o_ready`=0.
- **DONE:**
  - `o_valid`=1; `o_prd` and `o_signed` are held stable.
  - On `i_ready`, go to IDLE, or go directly to BUSY if `i_valid` is also 1 (capture in the same cycle).
  - `o_ready` = `i_ready` in DONE, combinationally.
- **Arithmetic:**
  - Each operand is extended to `bit_width+1` bits: sign extension if signed, zero extension otherwise.
  - The exact product is `2*bit_width+2` bits, then resized to `prd_width` (see Configuration).
  - When `prd_width` = `2*bit_width+1`, results are always exact.
- Elements of `o_prd` not yet written in the current transaction keep their previous values. Only DONE guarantees a complete vector.
- Inputs present while `o_ready`=0 are ignored.

## Timing

- **Reset:**
  - When `i_rst_n`=0 at a clock edge: state=IDLE, `k`=0, `o_valid`=0, `o_ready`=1 after the edge, all `o_prd`=0, `o_signed`=0.
  - Reset applies in any state. A mid-BUSY or mid-DONE transaction is discarded with no output.
- **Latency:** the input is accepted at edge T; `o_valid` rises after edge T+N.
- **Throughput:** one vector per N+1 cycles with `i_ready` held high.
- `o_valid` and `o_prd` must not change while `o_valid`=1 and `i_ready`=0.
- `o_ready` is the only combinational output. `o_valid`, `o_prd` and `o_signed` are registered.
- N=1 is legal: BUSY lasts one cycle.

## Configuration

- `VEC_MUL_INT_SAT_EN` defined:
  - A product outside the `prd_width` range clamps to the max or min of that range, signed or unsigned per the captured mode.
  - Unsigned results clamp to 2^`prd_width`-1.
- Macro undefined: products truncate to the low `prd_width` bits (wrap).
- The macro has no effect when `prd_width` ≥ `2*bit_width` for unsigned operands, or ≥ `2*bit_width`-1+1 for signed operands, except for the -2^(bw-1)² corner, which requires `2*bit_width` bits.

## Structure

- Package `vec_mul_int_pkg`:
  - FSM state enum (`IDLE`, `BUSY`, `DONE`).
  - Functions `sat_max(prd_width, signed)` and `sat_min(prd_width, signed)`.
- Sub-module `vec_mul_lane`: a single combinational lane covering extend, multiply and resize/saturate, instantiated `lanes` times.
- Top level: FSM, counter, operand capture registers, lane-select mux, result registers.

## Test plan

Configuration: `bit_width`=8, `length`=4, `lanes`=2, `prd_width`=16 unless stated.

1. **Signed products:** signed A={-128,127,-1,3}, B={-128,127,5,-7} → `o_prd`={16384,16129,-5,-21}, `o_valid` 2 cycles after acceptance.
2. **Unsigned products:** unsigned A={255,255,0,1}, B={255,1,200,200} → {65025 (16'hFE01), 255, 0, 200}, `o_signed`=0.
3. **Backpressure:** hold `i_ready`=0 for 5 cycles in DONE → `o_valid`, `o_prd` and `o_signed` stable, `o_ready`=0, new `i_valid` ignored.
4. **Back-to-back:** `i_valid` and `i_ready` held high with 3 distinct vectors → each accepted in the DONE cycle of its predecessor, results every 3 cycles, in order.
5. **Reset mid-BUSY:** assert `i_rst_n`=0 for one edge after beat 0 → `o_valid`=0, `o_prd`=all 0, `o_ready`=1, and no result ever emitted for that vector.
6. **Narrow product:** `prd_width`=12, signed, 127×127 and -128×127:
   - With `VEC_MUL_INT_SAT_EN` → 2047 and -2048.
   - Without → -255 and 128.
